// File: rtl/wb_rr_arbiter.sv
// Four-master Wishbone round-robin arbiter with a stall watchdog.
// state | meaning: IDLE no owner | OWN owner routed to slave | ABORT watchdog fired, wait for owner cyc drop
module wb_rr_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_n_i,
  input  logic [3:0]   m_cyc_i,
  input  logic [3:0]   m_stb_i,
  input  logic [3:0]   m_we_i,
  input  logic [15:0]  m_sel_i,
  input  logic [127:0] m_adr_i,
  input  logic [127:0] m_dat_i,
  output logic [31:0]  m_dat_o,
  output logic [3:0]   m_ack_o,
  output logic [3:0]   m_err_o,
  output logic         s_cyc_o,
  output logic         s_stb_o,
  output logic         s_we_o,
  output logic [3:0]   s_sel_o,
  output logic [31:0]  s_adr_o,
  output logic [31:0]  s_dat_o,
  input  logic [31:0]  s_dat_i,
  input  logic         s_ack_i,
  input  logic         s_err_i,
  output logic [3:0]   grant_o,
  output logic         timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, ABORT = 2'd2} state_t;

  localparam logic [16:0] TO_CNT = 17'(TIMEOUT);
  localparam logic        TO_EN  = (TIMEOUT != 0);

  state_t      state, state_nxt;
  logic [1:0]  owner, owner_nxt, last, last_nxt, pick, cand;
  logic        pick_vld;
  logic [15:0] cnt, cnt_nxt;
  logic [3:0]  grant_nxt;
  logic        own_cyc, own_stb, stalled, fire;

  assign own_cyc = m_cyc_i[owner];
  assign own_stb = m_stb_i[owner];
  assign stalled = (state == OWN) && own_stb && !s_ack_i && !s_err_i;
  // Counter holds previously stalled cycles, so +1 counts the current one.
  assign fire    = TO_EN && stalled && (({1'b0, cnt} + 17'd1) == TO_CNT);
  assign m_dat_o = s_dat_i;

  // Walk offsets 4..1 so the closest requester after last wins.
  always_comb begin
    pick     = last;
    pick_vld = 1'b0;
    cand     = last;
    for (int i = 4; i >= 1; i--) begin
      cand = last + 2'(i);
      if (m_cyc_i[cand]) begin
        pick     = cand;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_adr_o   = '0;
    s_dat_o   = '0;
    m_ack_o   = '0;
    m_err_o   = '0;
    timeout_o = 1'b0;
    if (state == OWN) begin
      s_cyc_o        = own_cyc;
      s_stb_o        = own_stb;
      s_we_o         = m_we_i[owner];
      s_sel_o        = m_sel_i[{owner, 2'b00} +: 4];
      s_adr_o        = m_adr_i[{owner, 5'b00000} +: 32];
      s_dat_o        = m_dat_i[{owner, 5'b00000} +: 32];
      // A reset arriving mid-transfer must not leak a response to the owner.
      m_ack_o[owner] = s_ack_i & wb_rst_n_i;
      m_err_o[owner] = (s_err_i | fire) & wb_rst_n_i;
      timeout_o      = fire;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    grant_nxt = grant_o;
    cnt_nxt   = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = OWN;
          owner_nxt = pick;
          last_nxt  = pick;
          grant_nxt = 4'b0001 << pick;
        end
      end
      OWN: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (fire) begin
          state_nxt = ABORT;
        end else if (stalled) begin
          cnt_nxt = (cnt == '1) ? cnt : cnt + 16'd1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state   <= IDLE;
      owner   <= 2'd0;
      last    <= 2'd3;
      cnt     <= '0;
      grant_o <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      last    <= last_nxt;
      cnt     <= cnt_nxt;
      grant_o <= grant_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: integer-level arbitration model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_wb_rr_arbiter;
  localparam int TO = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   m_cyc, m_stb, m_we;
  logic [15:0]  m_sel;
  logic [127:0] m_adr, m_dat;
  logic [31:0]  m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]   m_ack_o, m_err_o, s_sel_o, grant_o;
  logic         s_cyc_o, s_stb_o, s_we_o, s_ack, s_err, timeout_o;

  always #5 clk = ~clk;

  wb_rr_arbiter #(.TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner index (-1 = none), abort flag, last granted, stalled-cycle count.
  int mo = -1;
  bit mab = 1'b0;
  int mlast = 3;
  int mstall = 0;
  bit chk_en = 1'b0;
  bit mst;

  always @(posedge clk) begin
    if (!rst_n) begin
      mo = -1; mab = 1'b0; mlast = 3; mstall = 0; chk_en = 1'b1;
    end else if (mo < 0) begin
      for (int k = 1; k <= 4; k++)
        if (mo < 0 && m_cyc[(mlast + k) % 4]) mo = (mlast + k) % 4;
      if (mo >= 0) mlast = mo;
      mstall = 0;
    end else if (mab) begin
      if (!m_cyc[mo]) begin mo = -1; mab = 1'b0; end
    end else begin
      mst = m_stb[mo] && !s_ack && !s_err;
      if (!m_cyc[mo]) begin mo = -1; mstall = 0; end
      else if (mst && mstall + 1 == TO) begin mab = 1'b1; mstall = 0; end
      else mstall = mst ? mstall + 1 : 0;
    end
  end

  bit act, fire;
  logic [3:0] e_grant, e_ack, e_err, e_sel;
  logic e_cyc, e_stb, e_we;
  logic [31:0] e_adr, e_dat;

  always @(negedge clk) begin
    if (chk_en) begin
      act = (mo >= 0) && !mab;
      fire = act && m_stb[mo] && !s_ack && !s_err && (mstall + 1 == TO);
      e_grant = (mo >= 0) ? 4'(1 << mo) : 4'd0;
      e_cyc = act ? m_cyc[mo] : 1'b0;
      e_stb = act ? m_stb[mo] : 1'b0;
      e_we  = act ? m_we[mo] : 1'b0;
      e_sel = act ? m_sel[mo*4 +: 4] : 4'd0;
      e_adr = act ? m_adr[mo*32 +: 32] : 32'd0;
      e_dat = act ? m_dat[mo*32 +: 32] : 32'd0;
      e_ack = (act && rst_n && s_ack) ? 4'(1 << mo) : 4'd0;
      e_err = (act && rst_n && (s_err || fire)) ? 4'(1 << mo) : 4'd0;
      chk("mdl_grant", 32'(grant_o), 32'(e_grant));
      chk("mdl_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, {29'd0, e_cyc, e_stb, e_we});
      chk("mdl_s_sel", 32'(s_sel_o), 32'(e_sel));
      chk("mdl_s_adr", s_adr_o, e_adr);
      chk("mdl_s_dat", s_dat_o, e_dat);
      chk("mdl_ack", 32'(m_ack_o), 32'(e_ack));
      chk("mdl_err", 32'(m_err_o), 32'(e_err));
      chk("mdl_timeout", 32'(timeout_o), 32'(fire));
      chk("mdl_m_dat", m_dat_o, s_dat_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int own;

  initial begin
    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    m_sel = 16'h5a3c;
    m_adr = {32'h3333_0030, 32'h2222_0020, 32'h1111_0010, 32'h0000_0000};
    m_dat = {32'hcccc_3333, 32'hbbbb_2222, 32'haaaa_1111, 32'h9999_0000};
    s_dat_i = 32'h1234_5678; s_ack = 1'b0; s_err = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);

    // Single write by master 2, slave acks on the second strobe cycle
    step();
    rst_n = 1'b1; m_cyc[2] = 1'b1; m_stb[2] = 1'b1; m_we[2] = 1'b1;
    m_sel[11:8] = 4'hf; m_adr[95:64] = 32'h0000_0004; m_dat[95:64] = 32'hdead_beef;
    @(negedge clk); chk("t1_grant_pre", 32'(grant_o), 32'd0);
    step();
    @(negedge clk);
    chk("t1_grant", 32'(grant_o), 32'h4);
    chk("t1_adr", s_adr_o, 32'h4);
    chk("t1_dat", s_dat_o, 32'hdead_beef);
    chk("t1_ack_early", 32'(m_ack_o), 32'd0);
    step(); s_ack = 1'b1;
    @(negedge clk); chk("t1_ack", 32'(m_ack_o), 32'h4);
    step(); s_ack = 1'b0; m_cyc[2] = 1'b0; m_stb[2] = 1'b0; m_we[2] = 1'b0;
    @(negedge clk); chk("t1_ack_done", 32'(m_ack_o), 32'd0);
    step();
    @(negedge clk); chk("t1_release", 32'(grant_o), 32'd0);

    // Round robin with 3-cycle tenures after a fresh reset
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1; m_cyc = 4'hf;
    step();
    for (int i = 0; i < 5; i++) begin
      own = i % 4;
      @(negedge clk); chk("rr_grant", 32'(grant_o), 32'(1 << own));
      step(); step();
      if (i == 4) m_cyc = '0; else m_cyc[own] = 1'b0;
      step();
      @(negedge clk); chk("rr_gap", 32'(grant_o), 32'd0);
      step();
      if (i < 4) m_cyc[own] = 1'b1;
    end

    // Watchdog: master 1 stalls, master 3 waits
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_cyc[3] = 1'b1; m_stb[3] = 1'b1;
    step();
    @(negedge clk);
    chk("wd_grant", 32'(grant_o), 32'h2);
    chk("wd_to_c1", 32'(timeout_o), 32'd0);
    step(); step();
    @(negedge clk);
    chk("wd_err_c3", 32'(m_err_o), 32'd0);
    chk("wd_to_c3", 32'(timeout_o), 32'd0);
    step();
    @(negedge clk);
    chk("wd_err_c4", 32'(m_err_o), 32'h2);
    chk("wd_to_c4", 32'(timeout_o), 32'd1);
    step(); s_ack = 1'b1;
    @(negedge clk);
    chk("wd_abort_cyc", 32'(s_cyc_o), 32'd0);
    chk("wd_late_ack", 32'(m_ack_o), 32'd0);
    chk("wd_no_m3", 32'(grant_o[3]), 32'd0);
    step(); s_ack = 1'b0; m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    @(negedge clk); chk("wd_no_m3_b", 32'(grant_o[3]), 32'd0);
    step();
    @(negedge clk); chk("wd_idle", 32'(grant_o), 32'd0);
    step();
    @(negedge clk); chk("wd_m3", 32'(grant_o), 32'h8);
    step(); m_cyc[3] = 1'b0; m_stb[3] = 1'b0;
    step();

    // Block read by master 0 while master 3 requests
    m_cyc[0] = 1'b1; m_cyc[3] = 1'b1;
    step();
    for (int d = 1; d <= 4; d++) begin
      m_stb[0] = 1'b1; s_ack = 1'b1; s_dat_i = 32'(d);
      @(negedge clk);
      chk("blk_ack", 32'(m_ack_o), 32'h1);
      chk("blk_dat", m_dat_o, 32'(d));
      chk("blk_grant", 32'(grant_o), 32'h1);
      step();
    end
    m_stb[0] = 1'b0; s_ack = 1'b0; m_cyc[0] = 1'b0;
    @(negedge clk);
    chk("blk_hold", 32'(grant_o), 32'h1);
    chk("blk_ack_end", 32'(m_ack_o), 32'd0);
    step();
    @(negedge clk); chk("blk_gap", 32'(grant_o), 32'd0);
    step();
    @(negedge clk); chk("blk_m3", 32'(grant_o), 32'h8);

    // Reset while master 3 owns and stalls
    m_stb[3] = 1'b1;
    step(); step();
    rst_n = 1'b0; m_cyc[0] = 1'b1;
    @(negedge clk);
    chk("rm_ack", 32'(m_ack_o), 32'd0);
    chk("rm_err", 32'(m_err_o), 32'd0);
    step(); rst_n = 1'b1;
    @(negedge clk);
    chk("rm_grant", 32'(grant_o), 32'd0);
    chk("rm_s_cyc", 32'(s_cyc_o), 32'd0);
    chk("rm_resp", 32'({m_ack_o, m_err_o}), 32'd0);
    step();
    @(negedge clk); chk("rm_first", 32'(grant_o), 32'h1);
    step(); m_cyc = '0; m_stb = '0;
    step(); step();

    // Ack arriving in the cycle the watchdog would fire
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    step();
    @(negedge clk); chk("tie_grant", 32'(grant_o), 32'h4);
    step(); step();
    @(negedge clk); chk("tie_to_c3", 32'(timeout_o), 32'd0);
    step(); s_ack = 1'b1;
    @(negedge clk);
    chk("tie_ack", 32'(m_ack_o), 32'h4);
    chk("tie_err", 32'(m_err_o), 32'd0);
    chk("tie_to", 32'(timeout_o), 32'd0);
    step(); s_ack = 1'b0;
    @(negedge clk);
    chk("tie_still_own", 32'(grant_o), 32'h4);
    chk("tie_s_cyc", 32'(s_cyc_o), 32'd1);
    step(); m_cyc = '0; m_stb = '0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
